// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter: two-requester round-robin arbiter feeding an 8N1 UART TX.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter logic [13:0] BAUD_DIV = 14'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       txd,
  output logic       busy,
  output logic       gnt_id,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [13:0] C_TERM = BAUD_DIV - 14'd1;

  state_t      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        ptr_q, ptr_d;
  logic        gnt_q, gnt_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic w_idle;
  logic w_pick0;
  logic w_pick1;
  logic w_hs;
  logic w_term;

  // Ready is offered only in IDLE and never while reset is asserted.
  always_comb begin
    w_idle     = (state_q == IDLE) && !rst;
    w_pick0    = req0_valid && (!req1_valid || !ptr_q);
    w_pick1    = req1_valid && (!req0_valid ||  ptr_q);
    req0_ready = w_idle && w_pick0;
    req1_ready = w_idle && w_pick1;
    w_hs       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    w_term     = (cnt_q == C_TERM);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (w_hs) begin
          state_d = START;
          cnt_d   = 14'd0;
          bit_d   = 3'd0;
          shift_d = req1_ready ? req1_data : req0_data;
          gnt_d   = req1_ready;
          // Pointer moves to the requester that lost this round.
          ptr_d   = req0_ready;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (w_term) begin
          state_d = DATA;
          cnt_d   = 14'd0;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end

      DATA: begin
        if (w_term) begin
          cnt_d = 14'd0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end

      STOP: begin
        if (w_term) begin
          state_d = IDLE;
          cnt_d   = 14'd0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 14'd0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 14'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign gnt_id     = gnt_q;
  assign frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter: directed self-checking bench, BAUD_DIV = 4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       txd, busy, gnt_id, frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.BAUD_DIV(14'd4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .txd        (txd),
    .busy       (busy),
    .gnt_id     (gnt_id),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after each rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Expected txd in cycle N+c after a handshake in cycle N (4 clocks per bit).
  function automatic logic exp_txd(input logic [7:0] b, input int c);
    if (c <= 4)       return 1'b0;
    else if (c <= 36) return b[(c - 5) / 4];
    else              return 1'b1;
  endfunction

  // Called in cycle N+1; returns positioned in cycle N+41 (first IDLE cycle).
  task automatic frame_check(input logic [7:0] b, input logic id, input bit toggle,
                             input int raise1_at, input logic [7:0] d1);
    for (int c = 1; c <= 40; c++) begin
      if (c == raise1_at) begin
        req1_valid = 1'b1;
        req1_data  = d1;
      end
      if (toggle) begin
        req0_data = 8'($urandom);
        req1_data = 8'($urandom);
      end
      #1;
      chk("txd", txd, exp_txd(b, c));
      chk("busy", busy, 1'b1);
      chk("gnt_id", gnt_id, id);
      chk("frame_done_low", frame_done, 1'b0);
      chk("ready_busy", {req0_ready, req1_ready}, 2'b00);
      step();
    end
    #1;
    chk("frame_done_pulse", frame_done, 1'b1);
    chk("busy_end", busy, 1'b0);
    chk("txd_end", txd, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;

    // Reset, with valids asserted to show no handshake under reset.
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_gnt", gnt_id, 1'b0);
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("rst_busy2", busy, 1'b0);
    chk("rst_ready2", {req0_ready, req1_ready}, 2'b00);

    // Single byte A5 from req0.
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hA5;
    #1;
    chk("single_ready", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 1'b0;
    frame_check(8'hA5, 1'b0, 1'b0, 0, 8'h00);
    chk("single_ready_after", {req0_ready, req1_ready}, 2'b00);

    // Contention right after reset: req0, then req1, then req0.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h3C;
    req1_valid = 1'b1; req1_data = 8'hC3;
    #1;
    chk("cont_ready0", {req0_ready, req1_ready}, 2'b10);
    step();
    frame_check(8'h3C, 1'b0, 1'b0, 0, 8'h00);
    chk("cont_ready1", {req0_ready, req1_ready}, 2'b01);
    step();
    frame_check(8'hC3, 1'b1, 1'b0, 0, 8'h00);
    chk("cont_ready2", {req0_ready, req1_ready}, 2'b10);
    step();
    frame_check(8'h3C, 1'b0, 1'b0, 0, 8'h00);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("cont_ready_off", {req0_ready, req1_ready}, 2'b00);

    // Starvation: req0 held, req1 raised mid-frame wins next.
    step();
    req0_valid = 1'b1; req0_data = 8'h11;
    #1;
    chk("starv_ready0", {req0_ready, req1_ready}, 2'b10);
    step();
    frame_check(8'h11, 1'b0, 1'b0, 20, 8'h22);
    chk("starv_ready1", {req0_ready, req1_ready}, 2'b01);
    step();
    frame_check(8'h22, 1'b1, 1'b0, 0, 8'h00);
    chk("starv_ready2", {req0_ready, req1_ready}, 2'b10);
    step();
    frame_check(8'h11, 1'b0, 1'b0, 0, 8'h00);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset during data bit 3 of a req1 frame.
    step();
    req1_valid = 1'b1; req1_data = 8'h5A;
    #1;
    chk("mid_ready1", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_valid = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      #1;
      chk("mid_txd", txd, exp_txd(8'h5A, c));
      if (c == 18) rst = 1'b1;
      else step();
    end
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_txd", txd, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", {req0_ready, req1_ready}, 2'b00);
    for (int c = 0; c < 45; c++) begin
      step();
      #1;
      chk("mid_no_done", frame_done, 1'b0);
      chk("mid_no_retx", txd, 1'b1);
    end
    step();
    req1_valid = 1'b1; req1_data = 8'h96;
    #1;
    chk("post_rst_ready1", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_valid = 1'b0;
    frame_check(8'h96, 1'b1, 1'b0, 0, 8'h00);

    // Data stability: both data buses scrambled every cycle of the frame.
    step();
    req1_valid = 1'b1; req1_data = 8'hE7;
    #1;
    chk("stab_ready1", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_valid = 1'b0;
    frame_check(8'hE7, 1'b1, 1'b1, 0, 8'h00);

    // Idle for 100 cycles with no valids.
    for (int c = 0; c < 100; c++) begin
      step();
      #1;
      chk("idle_txd", txd, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_ready", {req0_ready, req1_ready}, 2'b00);
      chk("idle_gnt", gnt_id, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
